// File: rtl/lbr_reader_if.sv
// Beat stream of the LBR readout engine: one {from,to,index} record per
// valid/ready handshake. The engine drives the master side.
interface lbr_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IW         = 4
) ();
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_from;
    logic [DATA_WIDTH-1:0] out_to;
    logic [IW-1:0]         out_index;

    modport master (
        output out_valid, out_from, out_to, out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_from, out_to, out_index,
        output out_ready
    );
endinterface

// File: rtl/lbr_reader.sv
// LBR readout engine: reads TOS, then walks LBR_SIZE records newest to
// oldest through the register file's single combinational read port and
// streams each {from,to} pair out on a valid/ready beat port.
module lbr_reader #(
    parameter int  DATA_WIDTH = 32,
    parameter int  LBR_SIZE   = 16,
    parameter bit  SKIP_ZERO  = 1'b1,
    localparam int IW         = $clog2(LBR_SIZE),
    localparam int AW         = IW + 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [AW-1:0]         read_sel,
    input  logic [DATA_WIDTH-1:0] read_data,
    lbr_reader_if.master          beat,
    output logic                  busy,
    output logic                  done,
    output logic [IW:0]           count
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_TOS  = 3'd1;
    localparam logic [2:0] S_RD_FROM = 3'd2;
    localparam logic [2:0] S_RD_TO   = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    localparam logic [IW:0] FULL = (IW + 1)'(LBR_SIZE);
    localparam logic [IW:0] ONE  = (IW + 1)'(1);

    typedef struct packed {
        logic [IW-1:0]         index;
        logic [DATA_WIDTH-1:0] from;
        logic [DATA_WIDTH-1:0] to;
    } rec_t;

    logic [2:0]    state, state_nxt;
    logic [IW-1:0] idx;
    logic [IW:0]   remaining;
    rec_t          rec;
    logic          launch, accept, skip_rec, last;

    // abort beats start in IDLE; an aborted OUT beat is never accepted
    assign launch   = start && !abort;
    assign accept   = (state == S_OUT) && beat.out_ready && !abort;
    // evaluated in RD_TO: FROM already captured, TO is on read_data
    assign skip_rec = SKIP_ZERO && (rec.from == '0) && (read_data == '0);
    assign last     = (remaining == ONE);

    assign beat.out_valid = (state == S_OUT);
    assign beat.out_from  = rec.from;
    assign beat.out_to    = rec.to;
    assign beat.out_index = rec.index;
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_FIN);

    // Read address decode; LBR_SIZE is a power of two so TO[k] = {01,k}
    always_comb begin
        read_sel = '0;
        case (state)
            S_RD_TOS:  read_sel = AW'(2 * LBR_SIZE);
            S_RD_FROM: read_sel = {2'b00, idx};
            S_RD_TO:   read_sel = {2'b01, idx};
            default:   read_sel = '0;
        endcase
    end

    // Next-state logic; abort forces FIN from any active state except FIN
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (launch) state_nxt = S_RD_TOS;
            S_RD_TOS:  state_nxt = S_RD_FROM;
            S_RD_FROM: state_nxt = S_RD_TO;
            S_RD_TO:   begin
                if (skip_rec) state_nxt = last ? S_FIN : S_RD_FROM;
                else          state_nxt = S_OUT;
            end
            S_OUT:     if (accept) state_nxt = last ? S_FIN : S_RD_FROM;
            S_FIN:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE) && (state != S_FIN)) state_nxt = S_FIN;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Walk pointer, record capture and beat counting
    always_ff @(posedge clock) begin
        if (reset) begin
            idx       <= '0;
            remaining <= '0;
            rec       <= '0;
            count     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        count     <= '0;
                        remaining <= '0;
                    end
                end
                S_RD_TOS: begin
                    idx       <= read_data[IW-1:0];
                    remaining <= FULL;
                end
                S_RD_FROM: rec.from <= read_data;
                S_RD_TO: begin
                    rec.to    <= read_data;
                    rec.index <= idx;
                    if (skip_rec) begin
                        remaining <= remaining - ONE;
                        idx       <= idx - 1'b1;
                    end
                end
                S_OUT: begin
                    if (accept) begin
                        count     <= count + ONE;
                        remaining <= remaining - ONE;
                        idx       <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lbr_reader.sv
// Bench for lbr_reader: two instances share one register-file image and
// control inputs, one with SKIP_ZERO=1 (dut0) and one with SKIP_ZERO=0 (dut1).
// Expected beats come from walking the record array in the bench.
module tb_lbr_reader;
    localparam int DW = 32;
    localparam int LS = 4;
    localparam int IW = 2;
    localparam int AW = 4;

    typedef struct {
        int unsigned   idx;
        logic [DW-1:0] from;
        logic [DW-1:0] to;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset, start, abort;
    logic [1:0]    rdy, vld, busy, done;
    logic [AW-1:0] sel   [2];
    logic [DW-1:0] rdata [2];
    logic [DW-1:0] ofrom [2];
    logic [IW:0]   cnt   [2];
    logic [DW-1:0] rf    [2*LS+1];

    beat_t exp_q [2][$];
    int    exp_cnt [2];
    int    exp_lat [2];
    int    beats_seen [2];
    int    done_seen [2];
    int    done_cyc [2];
    int    base [2];
    int    bbase [2];
    int    cyc = 0;
    int    s_cyc;
    int    tests = 0;
    int    fails = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    for (genvar i = 0; i < 2; i++) begin : g_dut
        lbr_reader_if #(.DATA_WIDTH(DW), .IW(IW)) bif ();
        assign bif.out_ready = rdy[i];
        assign vld[i]        = bif.out_valid;
        assign ofrom[i]      = bif.out_from;
        assign rdata[i]      = (sel[i] <= AW'(2 * LS)) ? rf[sel[i]] : 32'hBAD0_BAD0;

        lbr_reader #(.DATA_WIDTH(DW), .LBR_SIZE(LS), .SKIP_ZERO(i == 0)) u_dut (
            .clock    (clock),
            .reset    (reset),
            .start    (start),
            .abort    (abort),
            .read_sel (sel[i]),
            .read_data(rdata[i]),
            .beat     (bif),
            .busy     (busy[i]),
            .done     (done[i]),
            .count    (cnt[i])
        );

        // Monitor: any presented beat must equal the scoreboard head
        always @(negedge clock) begin
            beat_t b;
            if (!reset && !abort && bif.out_valid) begin
                tests++;
                if (exp_q[i].size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected dut%0d: idx=%0d from=%0h, none expected",
                             i, bif.out_index, bif.out_from);
                end else begin
                    chk($sformatf("beat_idx dut%0d", i), bif.out_index, exp_q[i][0].idx);
                    chk($sformatf("beat_from dut%0d", i), bif.out_from, exp_q[i][0].from);
                    chk($sformatf("beat_to dut%0d", i), bif.out_to, exp_q[i][0].to);
                    if (bif.out_ready) begin
                        b = exp_q[i].pop_front();
                        beats_seen[i]++;
                    end
                end
            end
            if (!reset && done[i]) begin
                done_seen[i]++;
                done_cyc[i] = cyc;
                chk($sformatf("count dut%0d", i), cnt[i], exp_cnt[i]);
                chk($sformatf("beats_left dut%0d", i), exp_q[i].size(), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: visit TOS, TOS-1, ... mod LS; zero records dropped when skipping
    task automatic load_exp();
        for (int i = 0; i < 2; i++) begin
            int nb = 0;
            int ns = 0;
            int tos = int'(rf[2*LS] % LS);
            exp_q[i].delete();
            for (int k = 0; k < LS; k++) begin
                int slot = (tos - k + LS) % LS;
                if (i == 0 && rf[slot] == 0 && rf[LS+slot] == 0) ns++;
                else begin
                    beat_t b;
                    b.idx  = slot;
                    b.from = rf[slot];
                    b.to   = rf[LS+slot];
                    exp_q[i].push_back(b);
                    nb++;
                end
            end
            exp_cnt[i] = nb;
            // edges from start sample to done: TOS read, 3 per beat, 2 per skip
            exp_lat[i] = 1 + 3 * nb + 2 * ns;
        end
    endtask

    task automatic start_dump();
        load_exp();
        for (int i = 0; i < 2; i++) begin
            base[i]  = done_seen[i];
            bbase[i] = beats_seen[i];
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, input bit rand_rdy, input bit chk_lat);
        int n = 0;
        while ((done_seen[0] == base[0] || done_seen[1] == base[1]) && n < budget) begin
            if (rand_rdy) rdy = 2'($urandom_range(0, 3));
            tick();
            n++;
        end
        chk("done_timeout", 64'(n >= budget), 0);
        if (chk_lat)
            for (int i = 0; i < 2; i++)
                chk($sformatf("latency dut%0d", i), done_cyc[i] - s_cyc, exp_lat[i]);
        rdy = 2'b11;
    endtask

    task automatic wait_beats(input int k);
        int n = 0;
        while ((beats_seen[0] - bbase[0] < k || beats_seen[1] - bbase[1] < k) && n < 50) begin
            tick();
            n++;
        end
        chk("beat_timeout", 64'(n >= 50), 0);
    endtask

    task automatic fill_seq();
        for (int k = 0; k < LS; k++) begin
            rf[k]    = 32'h100 + k;
            rf[LS+k] = 32'h200 + k;
        end
        rf[2*LS] = 32'd1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0 [2];
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        rdy   = 2'b11;
        for (int k = 0; k < 2 * LS; k++) rf[k] = '0;
        rf[2*LS] = LS - 1;
        for (int i = 0; i < 2; i++) begin
            beats_seen[i] = 0;
            done_seen[i]  = 0;
            exp_cnt[i]    = 0;
        end
        repeat (3) tick();

        // reset values
        chk("rst_busy", busy, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_valid", vld, 2'b00);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_count dut%0d", i), cnt[i], 0);
            chk($sformatf("rst_sel dut%0d", i), sel[i], 0);
            chk($sformatf("rst_from dut%0d", i), ofrom[i], 0);
        end
        reset = 1'b0;
        tick();

        // empty register file: dut0 emits nothing, dut1 emits four zero records
        start_dump();
        for (int i = 0; i < 2; i++) chk($sformatf("tos_sel dut%0d", i), sel[i], 2 * LS);
        wait_done(100, 1'b0, 1'b1);

        // sequential records, TOS=1, ready always high
        fill_seq();
        start_dump();
        wait_done(100, 1'b0, 1'b1);

        // stall the second beat for three cycles
        start_dump();
        wait_beats(1);
        rdy = 2'b00;
        repeat (5) tick();
        chk("stall_valid", vld, 2'b11);
        chk("stall_from", ofrom[0], 32'h100);
        rdy = 2'b11;
        wait_done(100, 1'b0, 1'b0);

        // record 0 zeroed
        rf[0]  = '0;
        rf[LS] = '0;
        start_dump();
        wait_done(100, 1'b0, 1'b1);

        // abort with second beat pending; start while busy is ignored
        fill_seq();
        start_dump();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_beats(1);
        rdy = 2'b00;
        n = 0;
        while (vld != 2'b11 && n < 20) begin
            tick();
            n++;
        end
        chk("abort_wait_timeout", 64'(n >= 20), 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            exp_cnt[i] = 1;
            exp_q[i].delete();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", vld, 2'b00);
        chk("abort_done", done, 2'b11);
        rdy = 2'b11;
        tick();
        chk("abort_done_1cyc", done, 2'b00);
        chk("abort_idle", busy, 2'b00);
        for (int i = 0; i < 2; i++)
            chk($sformatf("abort_pulses dut%0d", i), done_seen[i] - base[i], 1);

        // start and abort together in IDLE: stays idle, no done
        for (int i = 0; i < 2; i++) d0[i] = done_seen[i];
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 2'b00);
        repeat (2) tick();
        for (int i = 0; i < 2; i++)
            chk($sformatf("sa_no_done dut%0d", i), done_seen[i] - d0[i], 0);

        // reset mid-dump
        start_dump();
        wait_beats(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 2'b00);
        chk("mid_rst_valid", vld, 2'b00);
        chk("mid_rst_done", done, 2'b00);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mid_rst_count dut%0d", i), cnt[i], 0);
            exp_q[i].delete();
        end
        repeat (2) tick();
        for (int i = 0; i < 2; i++)
            chk($sformatf("mid_rst_no_done dut%0d", i), done_seen[i] - base[i], 0);

        // randomized records, TOS and back-pressure
        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < LS; k++) begin
                int r = $urandom_range(0, 3);
                rf[k]    = (r < 2) ? 32'd0 : $urandom;
                rf[LS+k] = (r == 0) ? 32'd0 : $urandom;
            end
            rf[2*LS] = $urandom;
            start_dump();
            if (it % 4 == 0) wait_done(200, 1'b0, 1'b1);
            else             wait_done(200, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
